rs_alu: RTL and testbench

- ALU reservation station directly upstream of the combinational ALU execute stage.
- Buffers dispatched integer, branch and jump ops until both source operands are valid.
- Captures operands from two CDB broadcasts, then issues one ready op per cycle into registered execute-input outputs.
- Sits between the decoder/dispatch stage and the ALU. The ROB provides tags and the flush signal.

---
 rtl/rs_alu_pkg.sv | 48 ++++
 rtl/rs_select.sv | 26 ++
 rtl/rs_alu.sv | 208 ++++++++++++++++++++
 tb/tb_rs_alu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_pkg.sv
// Shared widths, op encodings and empty values for the ALU reservation station
// and the execute stage it feeds.
package rs_alu_pkg;

  localparam int opTypeWidth = 6;
  localparam int dataWidth   = 32;
  localparam int addrWidth   = 32;
  localparam int immWidth    = 32;
  localparam int tagWidth    = 4;

  localparam logic [tagWidth-1:0]  emptyTag  = '0;
  localparam logic [dataWidth-1:0] emptyData = '0;
  localparam logic [addrWidth-1:0] emptyAddr = '0;

  typedef enum logic [opTypeWidth-1:0] {
    emptyOp  = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_OR    = 6'd4,
    OP_XOR   = 6'd5,
    OP_SLL   = 6'd6,
    OP_SRL   = 6'd7,
    OP_SRA   = 6'd8,
    OP_SLT   = 6'd9,
    OP_SLTU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_ANDI  = 6'd12,
    OP_ORI   = 6'd13,
    OP_XORI  = 6'd14,
    OP_SLLI  = 6'd15,
    OP_SRLI  = 6'd16,
    OP_SRAI  = 6'd17,
    OP_SLTI  = 6'd18,
    OP_SLTIU = 6'd19,
    OP_LUI   = 6'd20,
    OP_AUIPC = 6'd21,
    OP_BEQ   = 6'd22,
    OP_BNE   = 6'd23,
    OP_BLT   = 6'd24,
    OP_BGE   = 6'd25,
    OP_BLTU  = 6'd26,
    OP_BGEU  = 6'd27,
    OP_JAL   = 6'd28,
    OP_JALR  = 6'd29
  } op_e;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // NOTE: outputs get defaults before the loop so every path assigns them;
    // a path that leaves a comb output unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    // Scanning downward lets the lowest set bit win.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched ops until both operands are valid
// and issues one per cycle. Define RS_DISPATCH_BYPASS_EN for dispatch-to-issue bypass.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = tagWidth
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear_in,
  input  logic                   disp_valid_in,
  input  logic [opTypeWidth-1:0] disp_op_in,
  input  logic [dataWidth-1:0]   disp_vj_in,
  input  logic [dataWidth-1:0]   disp_vk_in,
  input  logic [TAG_W-1:0]       disp_qj_in,
  input  logic [TAG_W-1:0]       disp_qk_in,
  input  logic [immWidth-1:0]    disp_imm_in,
  input  logic [addrWidth-1:0]   disp_pc_in,
  input  logic [TAG_W-1:0]       disp_dest_in,
  input  logic [TAG_W-1:0]       alu_cdb_tag_in,
  input  logic [dataWidth-1:0]   alu_cdb_data_in,
  input  logic [TAG_W-1:0]       lsb_cdb_tag_in,
  input  logic [dataWidth-1:0]   lsb_cdb_data_in,
  output logic                   rs_full_out,
  output logic [opTypeWidth-1:0] op_type_ex,
  output logic [dataWidth-1:0]   data_rs1_ex,
  output logic [dataWidth-1:0]   data_rs2_ex,
  output logic [immWidth-1:0]    imm_ex,
  output logic [addrWidth-1:0]   pc_ex,
  output logic [TAG_W-1:0]       tag_in_rob
);

  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(emptyTag);

  logic [RS_SIZE-1:0]     busy;
  logic [opTypeWidth-1:0] op_q   [RS_SIZE];
  logic [dataWidth-1:0]   vj_q   [RS_SIZE];
  logic [dataWidth-1:0]   vk_q   [RS_SIZE];
  logic [TAG_W-1:0]       qj_q   [RS_SIZE];
  logic [TAG_W-1:0]       qk_q   [RS_SIZE];
  logic [immWidth-1:0]    imm_q  [RS_SIZE];
  logic [addrWidth-1:0]   pc_q   [RS_SIZE];
  logic [TAG_W-1:0]       dest_q [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] issue_onehot;
  logic [RS_SIZE-1:0] free_vec;
  logic               issue_found;
  logic [IDX_W-1:0]   issue_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;

  logic [dataWidth-1:0] fwd_vj, fwd_vk;
  logic [TAG_W-1:0]     fwd_qj, fwd_qk;
  logic                 disp_accept, disp_bypass, disp_alloc;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] && (qj_q[i] == NO_TAG) && (qk_q[i] == NO_TAG);
    end
  end

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_issue_sel (
    .req   (ready_vec),
    .found (issue_found),
    .idx   (issue_idx)
  );

  // The slot being issued this edge is reusable by a dispatch on the same edge.
  always_comb begin
    issue_onehot = issue_found ? (RS_SIZE'(1) << issue_idx) : '0;
    free_vec     = ~busy | issue_onehot;
  end

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  assign rs_full_out = &busy;

  // Same-cycle forwarding of the dispatched operands; ALU bus wins over LSB.
  always_comb begin
    fwd_vj = disp_vj_in;
    fwd_qj = disp_qj_in;
    fwd_vk = disp_vk_in;
    fwd_qk = disp_qk_in;
    if (disp_qj_in != NO_TAG) begin
      if (disp_qj_in == alu_cdb_tag_in) begin
        fwd_vj = alu_cdb_data_in;
        fwd_qj = NO_TAG;
      end else if (disp_qj_in == lsb_cdb_tag_in) begin
        fwd_vj = lsb_cdb_data_in;
        fwd_qj = NO_TAG;
      end
    end
    if (disp_qk_in != NO_TAG) begin
      if (disp_qk_in == alu_cdb_tag_in) begin
        fwd_vk = alu_cdb_data_in;
        fwd_qk = NO_TAG;
      end else if (disp_qk_in == lsb_cdb_tag_in) begin
        fwd_vk = lsb_cdb_data_in;
        fwd_qk = NO_TAG;
      end
    end
  end

  assign disp_accept = rdy_in && !clear_in && disp_valid_in && !rs_full_out;

`ifdef RS_DISPATCH_BYPASS_EN
  assign disp_bypass = disp_accept && !issue_found && (fwd_qj == NO_TAG) && (fwd_qk == NO_TAG);
`else
  assign disp_bypass = 1'b0;
`endif

  assign disp_alloc = disp_accept && !disp_bypass && free_found;

  // Busy bits and the registered execute-stage outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_in) begin
      busy        <= '0;
      op_type_ex  <= emptyOp;
      data_rs1_ex <= emptyData;
      data_rs2_ex <= emptyData;
      imm_ex      <= '0;
      pc_ex       <= emptyAddr;
      tag_in_rob  <= NO_TAG;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy        <= '0;
        op_type_ex  <= emptyOp;
        data_rs1_ex <= emptyData;
        data_rs2_ex <= emptyData;
        imm_ex      <= '0;
        pc_ex       <= emptyAddr;
        tag_in_rob  <= NO_TAG;
      end else begin
        busy <= (busy & ~issue_onehot) | (disp_alloc ? (RS_SIZE'(1) << free_idx) : '0);
        if (issue_found) begin
          op_type_ex  <= op_q[issue_idx];
          data_rs1_ex <= vj_q[issue_idx];
          data_rs2_ex <= vk_q[issue_idx];
          imm_ex      <= imm_q[issue_idx];
          pc_ex       <= pc_q[issue_idx];
          tag_in_rob  <= dest_q[issue_idx];
        end else if (disp_bypass) begin
          op_type_ex  <= disp_op_in;
          data_rs1_ex <= fwd_vj;
          data_rs2_ex <= fwd_vk;
          imm_ex      <= disp_imm_in;
          pc_ex       <= disp_pc_in;
          tag_in_rob  <= disp_dest_in;
        end else begin
          op_type_ex  <= emptyOp;
          data_rs1_ex <= emptyData;
          data_rs2_ex <= emptyData;
          imm_ex      <= '0;
          pc_ex       <= emptyAddr;
          tag_in_rob  <= NO_TAG;
        end
      end
    end
  end

  // NOTE: entry payload has no reset; busy gates every use, so stale contents
  // are never observed and the array stays plain RAM-like storage.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (disp_alloc && (free_idx == IDX_W'(i))) begin
          op_q[i]   <= disp_op_in;
          vj_q[i]   <= fwd_vj;
          qj_q[i]   <= fwd_qj;
          vk_q[i]   <= fwd_vk;
          qk_q[i]   <= fwd_qk;
          imm_q[i]  <= disp_imm_in;
          pc_q[i]   <= disp_pc_in;
          dest_q[i] <= disp_dest_in;
        end else if (busy[i]) begin
          if (qj_q[i] != NO_TAG) begin
            if (qj_q[i] == alu_cdb_tag_in) begin
              vj_q[i] <= alu_cdb_data_in;
              qj_q[i] <= NO_TAG;
            end else if (qj_q[i] == lsb_cdb_tag_in) begin
              vj_q[i] <= lsb_cdb_data_in;
              qj_q[i] <= NO_TAG;
            end
          end
          if (qk_q[i] != NO_TAG) begin
            if (qk_q[i] == alu_cdb_tag_in) begin
              vk_q[i] <= alu_cdb_data_in;
              qk_q[i] <= NO_TAG;
            end else if (qk_q[i] == lsb_cdb_tag_in) begin
              vk_q[i] <= lsb_cdb_data_in;
              qk_q[i] <= NO_TAG;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: expected issues are queued at dispatch/wakeup and
// compared field by field whenever the DUT presents a non-empty op.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   rdy_in;
  logic                   clear_in;
  logic                   disp_valid_in;
  logic [opTypeWidth-1:0] disp_op_in;
  logic [31:0]            disp_vj_in, disp_vk_in, disp_imm_in, disp_pc_in;
  logic [3:0]             disp_qj_in, disp_qk_in, disp_dest_in;
  logic [3:0]             alu_cdb_tag_in, lsb_cdb_tag_in;
  logic [31:0]            alu_cdb_data_in, lsb_cdb_data_in;
  logic                   rs_full_out;
  logic [opTypeWidth-1:0] op_type_ex;
  logic [31:0]            data_rs1_ex, data_rs2_ex, imm_ex, pc_ex;
  logic [3:0]             tag_in_rob;

  typedef struct {
    logic [opTypeWidth-1:0] op;
    logic [31:0]            rs1, rs2, imm, pc;
    logic [3:0]             tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  rs_alu dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_valid_in(disp_valid_in), .disp_op_in(disp_op_in),
    .disp_vj_in(disp_vj_in), .disp_vk_in(disp_vk_in),
    .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in),
    .disp_imm_in(disp_imm_in), .disp_pc_in(disp_pc_in), .disp_dest_in(disp_dest_in),
    .alu_cdb_tag_in(alu_cdb_tag_in), .alu_cdb_data_in(alu_cdb_data_in),
    .lsb_cdb_tag_in(lsb_cdb_tag_in), .lsb_cdb_data_in(lsb_cdb_data_in),
    .rs_full_out(rs_full_out), .op_type_ex(op_type_ex),
    .data_rs1_ex(data_rs1_ex), .data_rs2_ex(data_rs2_ex),
    .imm_ex(imm_ex), .pc_ex(pc_ex), .tag_in_rob(tag_in_rob)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every non-empty issue is matched against the head of the scoreboard.
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && op_type_ex != emptyOp) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'(op_type_ex), 32'(emptyOp));
      end else begin
        mon_e = sb.pop_front();
        check("iss_op",  32'(op_type_ex), 32'(mon_e.op));
        check("iss_rs1", data_rs1_ex,     mon_e.rs1);
        check("iss_rs2", data_rs2_ex,     mon_e.rs2);
        check("iss_imm", imm_ex,          mon_e.imm);
        check("iss_pc",  pc_ex,           mon_e.pc);
        check("iss_tag", 32'(tag_in_rob), 32'(mon_e.tag));
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid_in  = 1'b0;
    clear_in       = 1'b0;
    alu_cdb_tag_in = '0;
    lsb_cdb_tag_in = '0;
  endtask

  task automatic drive_disp(input logic [opTypeWidth-1:0] op, input logic [31:0] vj,
                            input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] dest);
    disp_valid_in = 1'b1;
    disp_op_in    = op;
    disp_vj_in    = vj;
    disp_vk_in    = vk;
    disp_qj_in    = qj;
    disp_qk_in    = qk;
    disp_imm_in   = imm;
    disp_pc_in    = pc;
    disp_dest_in  = dest;
  endtask

  task automatic push(input logic [opTypeWidth-1:0] op, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [3:0] tag);
    exp_t e;
    e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.pc = pc; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_op(input string tag, input int budget);
    int n = 0;
    while (op_type_ex == emptyOp && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(op_type_ex != emptyOp), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Order test entries 0..5: two woken by tag 10, four waiting on tag 13.
  logic [opTypeWidth-1:0] ord_op [6];
  logic [31:0]            ord_vj [6];
  logic [31:0]            ord_vk [6];
  logic [3:0]             ord_qj [6];
  logic [3:0]             ord_qk [6];

  initial begin
    ord_op = '{OP_SRL, OP_SRL, OP_AND, OP_SLL, OP_SLL, OP_OR};
    ord_vj = '{32'hA0, 32'hA1, 32'h0,  32'hA3, 32'hA4, 32'h0};
    ord_vk = '{32'h0,  32'h0,  32'hF0, 32'h0,  32'h0,  32'hF5};
    ord_qj = '{4'd0,   4'd0,   4'd10,  4'd0,   4'd0,   4'd10};
    ord_qk = '{4'd13,  4'd13,  4'd0,   4'd13,  4'd13,  4'd0};

    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    drive_disp(emptyOp, '0, '0, '0, '0, '0, '0, '0);
    disp_valid_in   = 1'b0;
    alu_cdb_data_in = '0;
    lsb_cdb_data_in = '0;

    repeat (2) step();
    check("rst_op",   32'(op_type_ex),  32'(emptyOp));
    check("rst_full", 32'(rs_full_out), 32'd0);
    check("rst_rs1",  data_rs1_ex,      32'd0);
    check("rst_tag",  32'(tag_in_rob),  32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    step();

    // Ready dispatch.
    drive_disp(OP_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 32'd0, 32'h40, 4'd3);
    push(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h40, 4'd3);
    step();
    idle();
`ifdef RS_DISPATCH_BYPASS_EN
    check("ready_lat1", 32'(op_type_ex), 32'(OP_ADD));
    step();
    check("ready_after", 32'(op_type_ex), 32'(emptyOp));
`else
    check("ready_lat1", 32'(op_type_ex), 32'(emptyOp));
    step();
    check("ready_lat2", 32'(op_type_ex), 32'(OP_ADD));
    step();
    check("ready_after", 32'(op_type_ex), 32'(emptyOp));
`endif

    // Wakeup through the ALU bus three cycles after dispatch.
    drive_disp(OP_ADDI, 32'd0, 32'd0, 4'd6, 4'd0, 32'd1, 32'h44, 4'd4);
    push(OP_ADDI, 32'h10, 32'd0, 32'd1, 32'h44, 4'd4);
    step();
    idle();
    step();
    step();
    check("wake_wait", 32'(op_type_ex), 32'(emptyOp));
    alu_cdb_tag_in  = 4'd6;
    alu_cdb_data_in = 32'h10;
    step();
    idle();
    check("wake_capture", 32'(op_type_ex), 32'(emptyOp));
    step();
    check("wake_issue", 32'(op_type_ex), 32'(OP_ADDI));
    step();

    // Same-cycle forwarding from the LSB bus.
    drive_disp(OP_SUB, 32'd2, 32'd0, 4'd0, 4'd9, 32'd0, 32'h48, 4'd5);
    lsb_cdb_tag_in  = 4'd9;
    lsb_cdb_data_in = 32'hFFFF_FFFF;
    push(OP_SUB, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'h48, 4'd5);
    step();
    idle();
    repeat (3) step();
    check("fwd_drained", 32'(sb.size()), 32'd0);

    // Dispatch while rdy_in is low is ignored.
    rdy_in = 1'b0;
    drive_disp(OP_OR, 32'd1, 32'd1, 4'd0, 4'd0, 32'd0, 32'h4C, 4'd6);
    repeat (2) step();
    idle();
    rdy_in = 1'b1;
    step();
    check("rdy_ignored", 32'(op_type_ex), 32'(emptyOp));

    // Fill all sixteen entries with ops waiting on distinct-ish tags.
    for (int i = 0; i < 16; i++) begin
      drive_disp(OP_XOR, 32'(i), 32'd0, 4'((i % 15) + 1), 4'd0, 32'd0, 32'h100 + 32'(4 * i), 4'(i));
      step();
    end
    idle();
    check("full_set", 32'(rs_full_out), 32'd1);
    drive_disp(OP_AND, 32'd99, 32'd1, 4'd0, 4'd0, 32'd0, 32'h200, 4'd7);
    step();
    idle();
    check("full_hold",    32'(rs_full_out), 32'd1);
    check("full_ignored", 32'(op_type_ex),  32'(emptyOp));
    alu_cdb_tag_in  = 4'd2;
    alu_cdb_data_in = 32'h22;
    push(OP_XOR, 32'h22, 32'd0, 32'd0, 32'h104, 4'd1);
    step();
    idle();
    check("full_wake", 32'(rs_full_out), 32'd1);
    step();
    check("full_issue", 32'(op_type_ex),  32'(OP_XOR));
    check("full_drop",  32'(rs_full_out), 32'd0);

    // Flush with a dispatch and a broadcast in the same cycle.
    drive_disp(OP_AND, 32'd3, 32'd4, 4'd0, 4'd0, 32'd0, 32'h204, 4'd8);
    clear_in        = 1'b1;
    alu_cdb_tag_in  = 4'd3;
    alu_cdb_data_in = 32'h33;
    step();
    idle();
    check("flush_op",   32'(op_type_ex),  32'(emptyOp));
    check("flush_full", 32'(rs_full_out), 32'd0);
    for (int t = 1; t < 16; t++) begin
      alu_cdb_tag_in = 4'(t);
      step();
    end
    idle();
    repeat (2) step();
    check("flush_quiet", 32'(op_type_ex), 32'(emptyOp));

    // Issue order and same-edge slot reuse.
    for (int i = 0; i < 6; i++) begin
      drive_disp(ord_op[i], ord_vj[i], ord_vk[i], ord_qj[i], ord_qk[i], 32'd0, 32'h300 + 32'(4 * i), 4'(i + 1));
      step();
    end
    idle();
    alu_cdb_tag_in  = 4'd10;
    alu_cdb_data_in = 32'h55;
    push(OP_AND, 32'h55, 32'hF0, 32'd0, 32'h308, 4'd3);
    push(OP_OR,  32'h55, 32'hF5, 32'd0, 32'h314, 4'd6);
    step();
    idle();
    drive_disp(OP_SLT, 32'hB0, 32'd0, 4'd0, 4'd13, 32'd0, 32'h318, 4'd7);
    step();
    idle();
    check("order_first", 32'(op_type_ex), 32'(OP_AND));
    step();
    check("order_second", 32'(op_type_ex), 32'(OP_OR));
    step();
    lsb_cdb_tag_in  = 4'd13;
    lsb_cdb_data_in = 32'h77;
    push(OP_SRL, 32'hA0, 32'h77, 32'd0, 32'h300, 4'd1);
    push(OP_SRL, 32'hA1, 32'h77, 32'd0, 32'h304, 4'd2);
    push(OP_SLT, 32'hB0, 32'h77, 32'd0, 32'h318, 4'd7);
    push(OP_SLL, 32'hA3, 32'h77, 32'd0, 32'h30C, 4'd4);
    push(OP_SLL, 32'hA4, 32'h77, 32'd0, 32'h310, 4'd5);
    step();
    idle();
    repeat (6) step();
    check("order_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset while an op sits on the execute outputs.
    drive_disp(OP_ADD, 32'd1, 32'd2, 4'd0, 4'd0, 32'd0, 32'h400, 4'd8);
    push(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h400, 4'd8);
    step();
    idle();
    wait_op("arst_issue_seen", 4);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_op",   32'(op_type_ex),  32'(emptyOp));
    check("arst_rs1",  data_rs1_ex,      32'd0);
    check("arst_rs2",  data_rs2_ex,      32'd0);
    check("arst_tag",  32'(tag_in_rob),  32'd0);
    check("arst_full", 32'(rs_full_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) step();
    check("arst_quiet", 32'(op_type_ex), 32'(emptyOp));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
